sound_sched: RTL and testbench
==============================

Name: sound_sched

Overview:
- Schedules and arbitrates the single speaker output between three sources:
  - per-lamp tones while a lamp is lit;
  - a multi-note high-score jingle;
  - a lose jingle.
- Sits beside the game controller, taking copies of its lamp, HS and LOSE outputs, and drives the speaker pin.
- Square-wave tones are generated in CLK cycles; note durations are counted in TICK pulses from the 10 kHz divider.

Parameters:
- TONE0_HALF, 28409, half-period in CLK cycles for lamp 0.
- TONE1_HALF, 22523, half-period for lamp 1.
- TONE2_HALF, 18939, half-period for lamp 2.
- TONE3_HALF, 14205, half-period for lamp 3.
- LOSE_HALF, 60000, half-period of the lose tone.
- NOTE_TICKS, 1500, duration of each HS jingle note, in TICK pulses.
- LOSE_TICKS, 8000, duration of the lose jingle, in TICK pulses.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- TICK  in  1  one-CLK-wide timing strobe (10 kHz).
- LAMP  in  2  index of the lit lamp.
- LAMP_ENA  in  1  lamp lit.
- LOSE  in  1  lose indicator (level; rising edge triggers).
- HS  in  1  high-score indicator (level; rising edge triggers).
- MUTE  in  1  forces SPK low; sequencing continues.
- SPK  out  1  speaker square wave.
- BUSY  out  1  high while a jingle (HS_J or LOSE_J) is playing.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; SPK=0; BUSY=0.
  - Tone counter, tick counter, note index and edge registers all cleared.
  - LOSE/HS history registers reset to 0, so a level already high at reset release counts as an edge.
- Edge detect: lose_edge = LOSE & ~LOSE_q and hs_edge = HS & ~HS_q, where the _q registers are sampled every CLK.
- States: IDLE, LAMP, HS_J, LOSE_J. Arbitration priority is LOSE_J > HS_J > LAMP > IDLE.
- Transitions, evaluated each CLK, first match wins:
  - lose_edge -> LOSE_J (from any state, including LOSE_J itself, which restarts the jingle).
  - hs_edge while not in LOSE_J -> HS_J (restart if already in HS_J). An hs_edge during LOSE_J is dropped.
  - In HS_J or LOSE_J with the duration not expired -> stay.
  - Jingle expired -> LAMP if LAMP_ENA, else IDLE.
  - In IDLE/LAMP: LAMP_ENA=1 -> LAMP; LAMP_ENA=0 -> IDLE.
- Tone generator:
  - Every entry into a tone, and every tone change, loads the half-counter with HALF-1 and forces SPK phase to 0 in that same cycle. Tone changes are: new state, new HS note, or LAMP value change while in LAMP.
  - Thereafter the counter decrements each CLK. At 0 it toggles the phase and reloads HALF-1.
  - Result: period = 2*HALF cycles; first SPK rise occurs HALF cycles after the load cycle.
- Tone selection per state:
  - LAMP: TONEx_HALF by the current LAMP value.
  - HS_J: three notes, in order TONE0_HALF, TONE2_HALF, TONE3_HALF.
  - LOSE_J: LOSE_HALF.
  - IDLE: SPK=0, counters held.
- Durations:
  - The tick counter is cleared on entry or restart. A TICK in the entry cycle is not counted.
  - HS_J: when the count reaches NOTE_TICKS, advance the note index and clear the count. The jingle expires after note 2 completes (3*NOTE_TICKS ticks total).
  - LOSE_J: expires when the count reaches LOSE_TICKS.
  - The exit transition occurs in the cycle after the terminating TICK.
- Outputs:
  - SPK = phase & ~MUTE & (state != IDLE), registered.
  - BUSY = (state == HS_J) | (state == LOSE_J), registered.
- LAMP_ENA behaviour:
  - LAMP_ENA dropping in LAMP -> IDLE next cycle; SPK=0.
  - LAMP_ENA is ignored during jingles.
- Simultaneous lose_edge and hs_edge -> LOSE_J; the HS edge is discarded.
- Reset mid-jingle aborts immediately; no state is retained.

Test Plan:
Sim parameters: TONE0..3_HALF=5,7,9,11; LOSE_HALF=20; NOTE_TICKS=2; LOSE_TICKS=4. TICK pulses every 100 CLK.
1. Reset release with all inputs low -> SPK=0, BUSY=0, stays IDLE for 500 cycles. Assert RST_N=0 mid-toggle -> SPK=0 asynchronously.
2. LAMP=2, LAMP_ENA=1:
   - SPK period is 18 cycles, first rise 9 cycles after entry.
   - Switch LAMP to 3 -> phase resets, period becomes 22.
   - LAMP_ENA=0 -> SPK=0 next cycle.
3. HS rising edge with no lamp lit:
   - BUSY=1; SPK periods 10, 18, 22, each lasting 2 TICKs.
   - BUSY=0 the cycle after the 6th counted TICK; return to IDLE.
4. LOSE edge at tick 3 of an HS jingle:
   - Preempts: period becomes 40; BUSY stays 1 for 4 TICKs.
   - HS edge during LOSE_J -> ignored.
   - LAMP_ENA=1 at expiry -> LAMP tone resumes.
5. LOSE and HS rising in the same cycle -> LOSE_J only; after LOSE_J expires there is no HS jingle.
6. MUTE=1 during an HS jingle -> SPK=0 throughout, BUSY timing unchanged. MUTE=0 mid-note -> SPK resumes in the correct phase, with no counter restart.

Source files
------------

// File: rtl/sound_sched_if.sv
// Speaker scheduler bus: copies of the game controller's lamp/HS/LOSE
// outputs plus the 10 kHz TICK strobe and MUTE, and the scheduler's outputs.
//   master : drives TICK, LAMP, LAMP_ENA, LOSE, HS, MUTE; observes SPK, BUSY
//   slave  : the scheduler itself
interface sound_sched_if;
    logic       TICK;
    logic [1:0] LAMP;
    logic       LAMP_ENA;
    logic       LOSE;
    logic       HS;
    logic       MUTE;
    logic       SPK;
    logic       BUSY;

    modport master (
        output TICK, LAMP, LAMP_ENA, LOSE, HS, MUTE,
        input  SPK, BUSY
    );

    modport slave (
        input  TICK, LAMP, LAMP_ENA, LOSE, HS, MUTE,
        output SPK, BUSY
    );
endinterface

// File: rtl/sound_sched.sv
// Speaker scheduler: arbitrates the single speaker pin between lamp tones,
// a three-note high-score jingle and a lose jingle (LOSE_J > HS_J > LAMP > IDLE).
// Square-wave half-periods are counted in CLK cycles; note durations in TICKs.
// Ports:
//   CLK   : system clock
//   RST_N : asynchronous active-low reset
//   bus   : sound_sched_if.slave
//           in  TICK, LAMP[1:0], LAMP_ENA, LOSE, HS, MUTE
//           out SPK (square wave), BUSY (jingle playing); both registered
module sound_sched #(
    parameter int unsigned TONE0_HALF = 28409,
    parameter int unsigned TONE1_HALF = 22523,
    parameter int unsigned TONE2_HALF = 18939,
    parameter int unsigned TONE3_HALF = 14205,
    parameter int unsigned LOSE_HALF  = 60000,
    parameter int unsigned NOTE_TICKS = 1500,
    parameter int unsigned LOSE_TICKS = 8000
) (
    input  logic         CLK,
    input  logic         RST_N,
    sound_sched_if.slave bus
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned HALF_MAX = max2(max2(max2(TONE0_HALF, TONE1_HALF),
                                                 max2(TONE2_HALF, TONE3_HALF)),
                                            LOSE_HALF);
    localparam int unsigned HALF_W   = $clog2(HALF_MAX + 1);
    localparam int unsigned TICK_MAX = max2(NOTE_TICKS, LOSE_TICKS);
    localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAMP   = 2'd1,
        ST_HS_J   = 2'd2,
        ST_LOSE_J = 2'd3
    } state_t;

    state_t              state;
    state_t              state_n;
    logic                lose_q;
    logic                hs_q;
    logic [1:0]          lamp_q;
    logic [HALF_W-1:0]   half_cnt;
    logic [HALF_W-1:0]   half_n;
    logic [HALF_W-1:0]   half_sel;
    logic                phase;
    logic                phase_n;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   tick_n;
    logic [1:0]          note_idx;
    logic [1:0]          note_n;
    logic                reload;
    logic                spk_q;
    logic                busy_q;

    logic lose_edge;
    logic hs_edge;
    logic note_done;
    logic lose_done;

    // Rising-edge detect; history regs reset to 0 so a level high at release counts.
    assign lose_edge = bus.LOSE & ~lose_q;
    assign hs_edge   = bus.HS & ~hs_q;
    assign note_done = (tick_cnt == TICK_W'(NOTE_TICKS));
    assign lose_done = (tick_cnt == TICK_W'(LOSE_TICKS));

    // Next state, note index, tick count and tone-reload request.
    always_comb begin
        state_n = state;
        note_n  = note_idx;
        tick_n  = tick_cnt;
        reload  = 1'b0;

        if (lose_edge) begin
            // Also restarts a running lose jingle; a coincident hs_edge is dropped.
            state_n = ST_LOSE_J;
            note_n  = 2'd0;
            tick_n  = '0;
            reload  = 1'b1;
        end else if (hs_edge && (state != ST_LOSE_J)) begin
            state_n = ST_HS_J;
            note_n  = 2'd0;
            tick_n  = '0;
            reload  = 1'b1;
        end else begin
            case (state)
                ST_HS_J: begin
                    if (note_done) begin
                        tick_n = '0;
                        if (note_idx == 2'd2) begin
                            state_n = bus.LAMP_ENA ? ST_LAMP : ST_IDLE;
                            note_n  = 2'd0;
                        end else begin
                            note_n = note_idx + 2'd1;
                            reload = 1'b1;
                        end
                    end else if (bus.TICK) begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                ST_LOSE_J: begin
                    if (lose_done) begin
                        state_n = bus.LAMP_ENA ? ST_LAMP : ST_IDLE;
                        tick_n  = '0;
                    end else if (bus.TICK) begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = bus.LAMP_ENA ? ST_LAMP : ST_IDLE;
                    note_n  = 2'd0;
                    tick_n  = '0;
                end
            endcase
        end

        // Any state change, or a lamp switch while lamp tone is playing, restarts the tone.
        if (state_n != state) begin
            reload = 1'b1;
        end
        if ((state == ST_LAMP) && (state_n == ST_LAMP) && (bus.LAMP != lamp_q)) begin
            reload = 1'b1;
        end
    end

    // Half-period reload value (HALF-1) for the tone that plays next cycle.
    always_comb begin
        half_sel = HALF_W'(TONE0_HALF - 1);
        case (state_n)
            ST_LAMP: begin
                case (bus.LAMP)
                    2'd0:    half_sel = HALF_W'(TONE0_HALF - 1);
                    2'd1:    half_sel = HALF_W'(TONE1_HALF - 1);
                    2'd2:    half_sel = HALF_W'(TONE2_HALF - 1);
                    default: half_sel = HALF_W'(TONE3_HALF - 1);
                endcase
            end
            ST_HS_J: begin
                case (note_n)
                    2'd0:    half_sel = HALF_W'(TONE0_HALF - 1);
                    2'd1:    half_sel = HALF_W'(TONE2_HALF - 1);
                    default: half_sel = HALF_W'(TONE3_HALF - 1);
                endcase
            end
            ST_LOSE_J: half_sel = HALF_W'(LOSE_HALF - 1);
            default:   half_sel = HALF_W'(TONE0_HALF - 1);
        endcase
    end

    // Square-wave generator; counters hold while idle.
    always_comb begin
        half_n  = half_cnt;
        phase_n = phase;
        if (state_n != ST_IDLE) begin
            if (reload) begin
                half_n  = half_sel;
                phase_n = 1'b0;
            end else if (half_cnt == '0) begin
                half_n  = half_sel;
                phase_n = ~phase;
            end else begin
                half_n = half_cnt - 1'b1;
            end
        end
    end

    // State and registered outputs; SPK follows the new phase in the load cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            lose_q   <= 1'b0;
            hs_q     <= 1'b0;
            lamp_q   <= 2'd0;
            half_cnt <= '0;
            phase    <= 1'b0;
            tick_cnt <= '0;
            note_idx <= 2'd0;
            spk_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            lose_q   <= bus.LOSE;
            hs_q     <= bus.HS;
            lamp_q   <= bus.LAMP;
            half_cnt <= half_n;
            phase    <= phase_n;
            tick_cnt <= tick_n;
            note_idx <= note_n;
            spk_q    <= phase_n & ~bus.MUTE & (state_n != ST_IDLE);
            busy_q   <= (state_n == ST_HS_J) || (state_n == ST_LOSE_J);
        end
    end

    assign bus.SPK  = spk_q;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_sound_sched.sv
// Directed bench for sound_sched with small timing parameters
// (tones 5/7/9/11, lose 20, 2 ticks per note, 4 lose ticks, TICK every 100 CLK).
module tb_sound_sched;

    logic CLK = 1'b0;
    logic RST_N;

    sound_sched_if sif();

    sound_sched #(
        .TONE0_HALF(5),
        .TONE1_HALF(7),
        .TONE2_HALF(9),
        .TONE3_HALF(11),
        .LOSE_HALF (20),
        .NOTE_TICKS(2),
        .LOSE_TICKS(4)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (sif)
    );

    always #5 CLK = ~CLK;

    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;
    int   tick_div = 0;
    int   load_c   = 0;
    int   cur_half = 1;
    int   mm       = 0;
    bit   model_on = 1'b0;
    logic tick_seen;
    int   tone_half [4];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; drives the TICK divider and compares SPK with the reference square wave.
    task automatic step();
        int expv;
        @(negedge CLK);
        cyc_n++;
        tick_seen = sif.TICK;
        tick_div++;
        if (tick_div == 100) begin
            sif.TICK = 1'b1;
            tick_div = 0;
        end else begin
            sif.TICK = 1'b0;
        end
        expv = 0;
        if (model_on && !sif.MUTE) expv = ((cyc_n - load_c) / cur_half) % 2;
        if (sif.SPK !== 1'(expv)) mm++;
    endtask

    // Tone (re)starts at the next clock edge with the given half period.
    task automatic reload(input int h);
        load_c   = cyc_n + 1;
        cur_half = h;
        model_on = 1'b1;
    endtask

    task automatic next_rise(output int at);
        logic prev;
        at   = -1;
        prev = sif.SPK;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!prev && sif.SPK) begin
                at = cyc_n;
                break;
            end
            prev = sif.SPK;
        end
    endtask

    // Runs a jingle whose entry edge is applied by the caller; notes 1/2 use h1/h2.
    task automatic play(input string tag, input int tpn, input int n_notes,
                        input int h1, input int h2, input int stop_at,
                        input int hs_at, input int unmute_at);
        int t;
        bit done;
        t    = 0;
        done = 1'b0;
        step();  // entry cycle: a TICK here is not counted
        check_eq({tag, "_busy_entry"}, int'(sif.BUSY), 1);
        if (hs_at > 0) sif.HS = 1'b0;
        for (int i = 1; i < 2000 && !done; i++) begin
            if (unmute_at > 0 && i == unmute_at) sif.MUTE = 1'b0;
            step();
            if (tick_seen) begin
                t++;
                if (t == hs_at) sif.HS = 1'b1;
                if (t == stop_at) begin
                    done = 1'b1;
                end else if (t == tpn * n_notes) begin
                    check_eq({tag, "_busy_last_tick"}, int'(sif.BUSY), 1);
                    if (sif.LAMP_ENA) reload(tone_half[sif.LAMP]);
                    else model_on = 1'b0;
                    step();
                    check_eq({tag, "_busy_end"}, int'(sif.BUSY), 0);
                    done = 1'b1;
                end else if (t % tpn == 0) begin
                    reload((t / tpn == 1) ? h1 : h2);
                end
            end
        end
        check_eq({tag, "_ticks"}, t, (stop_at > 0) ? stop_at : tpn * n_notes);
    endtask

    initial begin
        int a;
        int b;
        int busy_hi;

        tone_half    = '{5, 7, 9, 11};
        RST_N        = 1'b0;
        sif.TICK     = 1'b0;
        sif.LAMP     = 2'd0;
        sif.LAMP_ENA = 1'b0;
        sif.LOSE     = 1'b0;
        sif.HS       = 1'b0;
        sif.MUTE     = 1'b0;

        // 1: reset and idle with all inputs low
        repeat (3) step();
        check_eq("rst_spk", int'(sif.SPK), 0);
        check_eq("rst_busy", int'(sif.BUSY), 0);
        RST_N   = 1'b1;
        busy_hi = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (sif.BUSY) busy_hi++;
        end
        check_eq("idle_busy_cycles", busy_hi, 0);
        check_eq("idle_spk_model", mm, 0);
        mm = 0;

        // 2: lamp tones
        reload(9);
        sif.LAMP     = 2'd2;
        sif.LAMP_ENA = 1'b1;
        next_rise(a);
        check_eq("lamp2_first_rise", a - load_c, 9);
        next_rise(b);
        check_eq("lamp2_period", b - a, 18);
        reload(11);
        sif.LAMP = 2'd3;
        next_rise(a);
        check_eq("lamp3_first_rise", a - load_c, 11);
        next_rise(b);
        check_eq("lamp3_period", b - a, 22);
        model_on     = 1'b0;
        sif.LAMP_ENA = 1'b0;
        step();
        check_eq("lamp_off_spk", int'(sif.SPK), 0);
        repeat (20) step();
        check_eq("lamp_spk_model", mm, 0);
        mm = 0;

        // async reset while SPK is high
        sif.LAMP     = 2'd0;
        sif.LAMP_ENA = 1'b1;
        reload(5);
        next_rise(a);
        check_eq("lamp0_first_rise", a - load_c, 5);
        check_eq("pre_rst_spk", int'(sif.SPK), 1);
        #2 RST_N = 1'b0;
        #1;
        check_eq("async_rst_spk", int'(sif.SPK), 0);
        model_on     = 1'b0;
        sif.LAMP_ENA = 1'b0;
        repeat (3) step();
        RST_N = 1'b1;
        repeat (3) step();
        mm = 0;

        // 3: HS jingle, no lamp
        if (sif.TICK) step();
        reload(5);
        sif.HS = 1'b1;
        play("hs", 2, 3, 9, 11, 0, 0, 0);
        repeat (50) step();
        check_eq("hs_after_busy", int'(sif.BUSY), 0);
        check_eq("hs_spk_model", mm, 0);
        mm = 0;

        // 4: LOSE preempts HS at tick 3; HS edge during LOSE ignored; lamp resumes
        sif.HS = 1'b0;
        repeat (2) step();
        if (sif.TICK) step();
        reload(5);
        sif.HS = 1'b1;
        play("hs_pre", 2, 3, 9, 11, 3, 0, 0);
        reload(20);
        sif.LOSE     = 1'b1;
        sif.LAMP     = 2'd1;
        sif.LAMP_ENA = 1'b1;
        play("lose_pre", 4, 1, 0, 0, 0, 2, 0);
        repeat (60) step();
        check_eq("lose_lamp_busy", int'(sif.BUSY), 0);
        check_eq("lose_pre_spk_model", mm, 0);
        mm = 0;

        // 5: LOSE and HS together, TICK in the entry cycle
        model_on     = 1'b0;
        sif.LAMP_ENA = 1'b0;
        sif.LOSE     = 1'b0;
        sif.HS       = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 200 && !sif.TICK; i++) step();
        reload(20);
        sif.LOSE = 1'b1;
        sif.HS   = 1'b1;
        play("both", 4, 1, 0, 0, 0, 0, 0);
        busy_hi = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (sif.BUSY) busy_hi++;
        end
        check_eq("both_no_hs_busy", busy_hi, 0);
        check_eq("both_spk_model", mm, 0);
        mm = 0;

        // 6: HS jingle muted, unmuted mid-jingle
        sif.LOSE = 1'b0;
        sif.HS   = 1'b0;
        repeat (2) step();
        if (sif.TICK) step();
        sif.MUTE = 1'b1;
        reload(5);
        sif.HS = 1'b1;
        play("mute", 2, 3, 9, 11, 0, 0, 250);
        repeat (20) step();
        check_eq("mute_spk_model", mm, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
